rx_stat_counters: RTL and testbench
===================================

# rx_stat_counters

Parametrised receive-statistics block for the 10G MAC receive engine. Registers per-frame event strobes from the rx engine and accumulates them into `NUM_CNT` counters of `CNT_W` bits, one of which is a byte counter with a multi-byte increment. A host-side read port returns any counter, with optional clear-on-read. Replaces the fixed 18-bit increment-strobe register; counting now lives inside the receive clock domain.

## Interface
- `NUM_CNT`, default 18: number of counters (index 0..NUM_CNT-1).
- `CNT_W`, default 32: width of each event counter.
- `BYTE_IDX`, default 17: index of the byte counter.
- `BYTE_W`, default 48: width of the byte counter.
- `ADDR_W`, default 5: read address width; must satisfy 2^ADDR_W >= NUM_CNT.
- `rxclk  in  1`: receive clock. All logic is on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `stat_inc  in  NUM_CNT`: one-cycle event strobes; bit i adds +1 to counter i. Bit BYTE_IDX is ignored.
- `byte_inc  in  4`: bytes received this cycle, 0..8. Values above 8 are clamped to 8.
- `clr_all  in  1`: clears every counter.
- `rd_req  in  1`: read request, one-cycle pulse.
- `rd_addr  in  ADDR_W`: counter index to read.
- `rd_clr  in  1`: qualifies `rd_req`; clears the addressed counter after reading it.
- `rd_ack  out  1`: one-cycle read acknowledge.
- `rd_data  out  max(CNT_W,BYTE_W)`: read value, zero-extended.

## Operation
- **Input stage.** `stat_inc` and `byte_inc` are registered once (stage S1). Counters update from S1.
- **Event counter i update**, applied in this priority order:
  - `clr_all`: counter becomes 0. Any S1 increment in the same cycle is dropped.
  - Clear-on-read of index i: counter becomes the S1 increment (0 or 1). No event is lost.
  - Otherwise: counter becomes counter + S1 increment.
- **Byte counter.** Same rules as event counters, but the increment is the clamped `byte_inc` (0..8). Width is BYTE_W.
- **Overflow.** Wrap modulo 2^width unless saturation is compiled in (see Configuration).
- **Read port.**
  - `rd_req` at cycle N: `rd_ack`=1 and `rd_data` = counter value before the cycle-N update, both at cycle N+1.
  - `rd_data` holds until the next ack.
  - Back-to-back requests are accepted every cycle.
  - An out-of-range address (`rd_addr` >= NUM_CNT) returns 0 with `rd_ack`, and `rd_clr` has no effect.
- **`rd_clr` with `clr_all` in the same cycle.** `clr_all` wins; the read still returns the pre-clear value.
- **Reset.** All counters = 0, S1 = 0, `rd_ack` = 0, `rd_data` = 0.
  - A read in flight when reset is asserted is discarded: no ack.
  - Events that are in S1 during reset are lost.

## Timing
- Event strobe at cycle N reaches S1 at N+1 and is counted in the counter at N+2.
- A read at cycle N+1 therefore does not yet see that event. A read at N+2 or later does.
- Read latency is fixed at 1 cycle. No stall or backpressure.
- Single-cycle adder per counter. BYTE_W = 48 must close timing at 156.25 MHz.

## Configuration
- `RX_STAT_SATURATE_EN` defined: each counter sticks at all-ones and no longer increments. Clear-on-read and `clr_all` still zero it.
- `RX_STAT_SATURATE_EN` undefined: counters wrap, so all-ones + 1 = 0 and all-ones + k = k-1.

## Structure
- **Package `rx_stat_pkg`.** Counter index localparams:
  - Indices 0–12: FRAMES_OK, FCS_ERR, BCAST_OK, MCAST_OK, LEN_64, LEN_65_127, LEN_128_255, LEN_256_511, LEN_512_1023, LEN_1024_MAX, CTRL_OK, LEN_RANGE_ERR, PAUSE_OK.
  - Indices 14–17: OVERSIZE_OK, UNDERSIZE, FRAGMENT, BYTES.
  - Index 13 is reserved and reads 0. It is never incremented because its strobe is tied off.
  - Also holds the clamp limit for `byte_inc` (8).
- **Sub-module `rx_stat_cnt`**, parametrised by width.
  - Contains one counter with inputs inc value, clr and rd_clr.
  - Saturate/wrap logic sits under the macro.
  - Instantiated NUM_CNT times with a generate loop; BYTE_IDX gets width BYTE_W.

## Test plan
- **Basic count.** Reset, then 5 pulses on `stat_inc[0]` -> read addr 0 two cycles later returns 5 with `rd_ack` one cycle after `rd_req`.
- **Byte clamp.** `byte_inc` = 8, 8, 3, 15 on consecutive cycles -> byte counter = 27 (15 clamped to 8).
- **Clear-on-read race.** Counter 2 = 7; `rd_req` + `rd_clr` in the same cycle that S1 holds a `stat_inc[2]` event -> `rd_data` = 7 and counter afterwards = 1.
- **Overflow.** Set CNT_W = 4 and drive 17 pulses -> read returns 1 when the macro is undefined, 15 when `RX_STAT_SATURATE_EN` is defined.
- **Boundary clears.**
  - `clr_all` concurrent with `rd_req` addr 5 (value 9) -> `rd_data` = 9, then all counters read 0.
  - `rd_addr` = 20 -> ack with data 0.
- **Mid-operation reset.** Assert `reset` the cycle after `rd_req` -> no `rd_ack`, and all counters and outputs read 0.

Source files
------------

// File: rtl/rx_stat_counters_pkg.sv
// Receive-statistics counter map and byte-increment clamp shared by the rx_stat blocks.
// Pure definitions: no logic, no latency, no backpressure.
package rx_stat_pkg;

  localparam int FRAMES_OK     = 0;
  localparam int FCS_ERR       = 1;
  localparam int BCAST_OK      = 2;
  localparam int MCAST_OK      = 3;
  localparam int LEN_64        = 4;
  localparam int LEN_65_127    = 5;
  localparam int LEN_128_255   = 6;
  localparam int LEN_256_511   = 7;
  localparam int LEN_512_1023  = 8;
  localparam int LEN_1024_MAX  = 9;
  localparam int CTRL_OK       = 10;
  localparam int LEN_RANGE_ERR = 11;
  localparam int PAUSE_OK      = 12;
  localparam int RSVD_13       = 13;
  localparam int OVERSIZE_OK   = 14;
  localparam int UNDERSIZE     = 15;
  localparam int FRAGMENT      = 16;
  localparam int BYTES         = 17;

  localparam int BYTE_INC_MAX  = 8;

  function automatic logic [3:0] clamp_byte_inc(input logic [3:0] v);
    return (v > 4'(BYTE_INC_MAX)) ? 4'(BYTE_INC_MAX) : v;
  endfunction

endpackage

// File: rtl/rx_stat_counters_if.sv
// Event-strobe and host read-port bundle between the rx engine/host and rx_stat_counters.
// Master drives strobes and read requests; slave answers with a one-cycle ack, no backpressure.
interface rx_stat_counters_if #(
  parameter int NUM_CNT = 18,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 48
) ();

  logic [NUM_CNT-1:0] stat_inc;
  logic [3:0]         byte_inc;
  logic               clr_all;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_clr;
  logic               rd_ack;
  logic [DATA_W-1:0]  rd_data;

  modport master (
    output stat_inc, byte_inc, clr_all, rd_req, rd_addr, rd_clr,
    input  rd_ack, rd_data
  );

  modport slave (
    input  stat_inc, byte_inc, clr_all, rd_req, rd_addr, rd_clr,
    output rd_ack, rd_data
  );

endinterface

// File: rtl/rx_stat_counters_cnt.sv
// One statistics counter: clr_all > clear-on-read (reloads the increment) > accumulate, 1-cycle update.
// Wraps by default; RX_STAT_SATURATE_EN makes it stick at all-ones. Never stalls.
module rx_stat_cnt #(
  parameter int W     = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] i_inc,
  input  logic             i_clr_all,
  input  logic             i_rd_clr,
  output logic [W-1:0]     o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_next;

`ifdef RX_STAT_SATURATE_EN
  logic [W:0] w_sum;
  assign w_sum  = {1'b0, r_cnt} + (W+1)'(i_inc);
  assign w_next = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
`else
  assign w_next = r_cnt + W'(i_inc);
`endif

  // Clear-on-read reloads the pending increment so an event racing the read is kept.
  always_ff @(posedge clk) begin
    if (reset || i_clr_all) begin
      r_cnt <= '0;
    end else if (i_rd_clr) begin
      r_cnt <= W'(i_inc);
    end else begin
      r_cnt <= w_next;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rx_stat_counters.sv
// Rx statistics: strobes registered once (S1), counted next cycle; host read returns pre-update value 1 cycle later.
// No backpressure; reads accepted every cycle. RX_STAT_SATURATE_EN selects saturating counters.
module rx_stat_counters
  import rx_stat_pkg::*;
#(
  parameter int NUM_CNT  = 18,
  parameter int CNT_W    = 32,
  parameter int BYTE_IDX = 17,
  parameter int BYTE_W   = 48,
  parameter int ADDR_W   = 5
) (
  input  logic              rxclk,
  input  logic              reset,
  rx_stat_counters_if.slave bus
);

  localparam int DATA_W = (CNT_W > BYTE_W) ? CNT_W : BYTE_W;

  logic [NUM_CNT-1:0] r_s1_inc;
  logic [3:0]         r_s1_bytes;
  logic               r_rd_ack;
  logic [DATA_W-1:0]  r_rd_data;
  logic [DATA_W-1:0]  w_cnt [NUM_CNT];
  logic [NUM_CNT-1:0] w_rd_clr;
  logic [DATA_W-1:0]  w_rd_val;

  always_ff @(posedge rxclk) begin
    if (reset) begin
      r_s1_inc   <= '0;
      r_s1_bytes <= '0;
    end else begin
      r_s1_inc   <= bus.stat_inc;
      r_s1_bytes <= clamp_byte_inc(bus.byte_inc);
    end
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    assign w_rd_clr[gi] = bus.rd_req & bus.rd_clr & (bus.rd_addr == ADDR_W'(gi));

    if (gi == BYTE_IDX) begin : g_byte
      logic [BYTE_W-1:0] w_val;
      logic              w_unused_strobe;
      assign w_unused_strobe = r_s1_inc[gi];
      rx_stat_cnt #(.W(BYTE_W), .INC_W(4)) u_cnt (
        .clk       (rxclk),
        .reset     (reset),
        .i_inc     (r_s1_bytes),
        .i_clr_all (bus.clr_all),
        .i_rd_clr  (w_rd_clr[gi]),
        .o_cnt     (w_val)
      );
      assign w_cnt[gi] = DATA_W'(w_val);
    end else begin : g_evt
      logic [CNT_W-1:0] w_val;
      logic             w_inc;
      logic             w_unused_strobe;
      // The reserved slot keeps its storage but its strobe is tied off, so it always reads 0.
      assign w_inc           = (gi == RSVD_13) ? 1'b0 : r_s1_inc[gi];
      assign w_unused_strobe = r_s1_inc[gi];
      rx_stat_cnt #(.W(CNT_W), .INC_W(1)) u_cnt (
        .clk       (rxclk),
        .reset     (reset),
        .i_inc     (w_inc),
        .i_clr_all (bus.clr_all),
        .i_rd_clr  (w_rd_clr[gi]),
        .o_cnt     (w_val)
      );
      assign w_cnt[gi] = DATA_W'(w_val);
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (bus.rd_addr == ADDR_W'(k)) w_rd_val = w_cnt[k];
    end
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= w_rd_val;
    end
  end

  // Masking with reset drops an ack that was already registered when reset arrives.
  assign bus.rd_ack  = r_rd_ack & ~reset;
  assign bus.rd_data = reset ? '0 : r_rd_data;

endmodule

// File: tb/tb_rx_stat_counters.sv
// Directed bench for rx_stat_counters: scoreboard of expected read data checked on every ack.
module tb_rx_stat_counters;
  import rx_stat_pkg::*;

  logic rxclk = 1'b0;
  logic reset = 1'b1;
  always #5 rxclk = ~rxclk;

  rx_stat_counters_if #(.NUM_CNT(18), .ADDR_W(5), .DATA_W(48)) bus ();
  rx_stat_counters_if #(.NUM_CNT(18), .ADDR_W(5), .DATA_W(48)) bus4 ();

  rx_stat_counters u_dut (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (bus)
  );

  rx_stat_counters #(.CNT_W(4)) u_ovf (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (bus4)
  );

  int checks   = 0;
  int failures = 0;
  logic [47:0] exp_q [$];
  logic        mon_req;
  logic [47:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rxclk);
    #1;
  endtask

  task automatic pulse(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.stat_inc    = '0;
      bus.stat_inc[b] = 1'b1;
      cyc();
    end
    bus.stat_inc = '0;
  endtask

  task automatic rd(input int addr, input logic clr, input logic [47:0] exp);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'(addr);
    bus.rd_clr  = clr;
    exp_q.push_back(exp);
    cyc();
    bus.rd_req = 1'b0;
    bus.rd_clr = 1'b0;
  endtask

  // Ack must follow each sampled request by exactly one cycle; data is popped from the scoreboard.
  always begin
    @(posedge rxclk);
    mon_req = bus.rd_req;
    @(negedge rxclk);
    if (reset) begin
      if (mon_req && exp_q.size() > 0) mon_exp = exp_q.pop_front();
      chk("ack_in_reset", 64'(bus.rd_ack), 64'(0));
    end else begin
      chk("ack_timing", 64'(bus.rd_ack), 64'(mon_req));
      if (bus.rd_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_ack observed=1 expected=0");
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rd_data", 64'(bus.rd_data), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    bus.stat_inc  = '0; bus.byte_inc  = '0; bus.clr_all  = 1'b0;
    bus.rd_req    = 1'b0; bus.rd_addr = '0; bus.rd_clr   = 1'b0;
    bus4.stat_inc = '0; bus4.byte_inc = '0; bus4.clr_all = 1'b0;
    bus4.rd_req   = 1'b0; bus4.rd_addr = '0; bus4.rd_clr = 1'b0;

    cyc(); cyc(); cyc();
    @(negedge rxclk);
    chk("reset_rd_data", 64'(bus.rd_data), 64'(0));
    reset = 1'b0;
    cyc();
    rd(FRAMES_OK, 1'b0, 48'd0);

    // Basic count: 5 pulses, one idle cycle, then read.
    pulse(FRAMES_OK, 5);
    cyc();
    rd(FRAMES_OK, 1'b0, 48'd5);

    // Event at N is invisible to a read at N+1, visible at N+2.
    pulse(FCS_ERR, 1);
    rd(FCS_ERR, 1'b0, 48'd0);
    rd(FCS_ERR, 1'b0, 48'd1);

    // Byte clamp; the stat_inc strobe on the byte index must be ignored.
    bus.byte_inc = 4'd8; cyc();
    bus.byte_inc = 4'd8; cyc();
    bus.byte_inc = 4'd3; cyc();
    bus.byte_inc = 4'd15; bus.stat_inc[BYTES] = 1'b1; cyc();
    bus.byte_inc = 4'd0;  bus.stat_inc = '0; cyc();
    rd(BYTES, 1'b0, 48'd27);

    // Clear-on-read while S1 holds an event for the same counter.
    pulse(BCAST_OK, 8);
    rd(BCAST_OK, 1'b1, 48'd7);
    rd(BCAST_OK, 1'b0, 48'd1);
    cyc(); cyc();
    @(negedge rxclk);
    chk("rd_data_hold", 64'(bus.rd_data), 64'(1));

    // Reserved slot and out-of-range address.
    pulse(RSVD_13, 3);
    cyc();
    rd(RSVD_13, 1'b0, 48'd0);
    rd(20, 1'b1, 48'd0);
    rd(FRAMES_OK, 1'b0, 48'd5);

    // clr_all with a concurrent clear-on-read; the S1 event of counter 0 is dropped.
    pulse(LEN_65_127, 9);
    bus.stat_inc[FRAMES_OK] = 1'b1; cyc();
    bus.stat_inc = '0;
    bus.clr_all  = 1'b1;
    rd(LEN_65_127, 1'b1, 48'd9);
    bus.clr_all  = 1'b0;
    rd(FRAMES_OK, 1'b0, 48'd0);
    rd(LEN_65_127, 1'b0, 48'd0);
    rd(BCAST_OK, 1'b0, 48'd0);
    rd(BYTES, 1'b0, 48'd0);

    // Overflow on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      bus4.stat_inc = 18'd1; cyc();
    end
    bus4.stat_inc = '0; cyc();
    bus4.rd_req = 1'b1; bus4.rd_addr = 5'd0; cyc();
    bus4.rd_req = 1'b0;
    @(negedge rxclk);
    chk("ovf_ack", 64'(bus4.rd_ack), 64'(1));
`ifdef RX_STAT_SATURATE_EN
    chk("ovf_data", 64'(bus4.rd_data), 64'(15));
`else
    chk("ovf_data", 64'(bus4.rd_data), 64'(1));
`endif

    // Reset arriving the cycle after a read request swallows the ack.
    pulse(MCAST_OK, 2);
    cyc();
    rd(MCAST_OK, 1'b0, 48'd2);
    reset = 1'b1;
    cyc(); cyc();
    @(negedge rxclk);
    chk("mid_reset_data", 64'(bus.rd_data), 64'(0));
    reset = 1'b0;
    cyc();
    rd(MCAST_OK, 1'b0, 48'd0);
    rd(FCS_ERR, 1'b0, 48'd0);
    bus4.rd_req = 1'b1; bus4.rd_addr = 5'd0; cyc();
    bus4.rd_req = 1'b0;
    @(negedge rxclk);
    chk("ovf_after_reset", 64'(bus4.rd_data), 64'(0));

    cyc(); cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
